// File: rtl/regfile_scan_checker.sv
// -----------------------------------------------------------------------------
// regfile_scan_checker
//
// Purpose:
//   Lets a CPU run for a programmed number of cycles, then halts it, takes over
//   register read port A, and walks every register index comparing the read
//   data against an expected-value memory. Each failing register produces a
//   one-cycle mismatch pulse carrying its index, and the failures are counted.
//
// Ports:
//   clock_i           single clock, rising edge
//   reset_i           asynchronous active-high reset
//   start_i           one-cycle run request, honoured only in IDLE/DONE
//   num_cycles_i      CPU cycles to run, sampled with start_i
//   rwe_i, rd_i       CPU register write enable / destination (write counting)
//   cpu_hold_o        keeps the CPU out of execution whenever not in RUN
//   test_mode_o       checker owns read port A (SCAN and DRAIN)
//   rs1_test_o        register index driven onto read port A
//   exp_addr_o        expected-value memory address (same as rs1_test_o)
//   regA_i            read port A data, READ_LATENCY cycles after the index
//   exp_data_i        expected data, READ_LATENCY cycles after the address
//   mismatch_valid_o  one-cycle pulse per failing register
//   mismatch_reg_o    index of the failing register (zero when no pulse)
//   write_count_o     saturating count of RUN writes to non-zero registers
//   err_count_o       mismatches in the current scan, saturating at 63
//   done_o, pass_o    scan finished / finished with zero mismatches
// -----------------------------------------------------------------------------
module regfile_scan_checker #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_REGS     = 32,
    parameter int CYCLE_WIDTH  = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   start_i,
    input  logic [CYCLE_WIDTH-1:0] num_cycles_i,
    input  logic                   rwe_i,
    input  logic [4:0]             rd_i,
    output logic                   cpu_hold_o,
    output logic                   test_mode_o,
    output logic [4:0]             rs1_test_o,
    output logic [4:0]             exp_addr_o,
    input  logic [DATA_WIDTH-1:0]  regA_i,
    input  logic [DATA_WIDTH-1:0]  exp_data_i,
    output logic                   mismatch_valid_o,
    output logic [4:0]             mismatch_reg_o,
    output logic [CYCLE_WIDTH-1:0] write_count_o,
    output logic [5:0]             err_count_o,
    output logic                   done_o,
    output logic                   pass_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_SCAN,
        S_DRAIN,
        S_DONE
    } state_e;

    localparam logic [4:0] LAST_IDX   = 5'(NUM_REGS - 1);
    localparam logic [1:0] LAST_DRAIN = 2'(READ_LATENCY - 1);
    localparam logic [5:0] ERR_MAX    = 6'h3F;

    state_e                 state_q, state_d;
    logic [CYCLE_WIDTH-1:0] cnt_q, cnt_d;
    logic [4:0]             idx_q, idx_d;
    logic [1:0]             drain_q, drain_d;
    logic [CYCLE_WIDTH-1:0] wcnt_q, wcnt_d;
    logic [5:0]             err_q, err_d;

    // Tag pipeline: stage 0 captures the index issued this cycle, the last
    // stage lines up with the read data coming back on regA_i / exp_data_i.
    logic [READ_LATENCY-1:0] vld_pipe_q;
    logic [4:0]              tag_pipe_q [READ_LATENCY];

    logic       cmp_vld;
    logic [4:0] cmp_tag;
    logic       cmp_mis;

    assign cmp_vld = vld_pipe_q[READ_LATENCY-1];
    assign cmp_tag = tag_pipe_q[READ_LATENCY-1];
    assign cmp_mis = cmp_vld && (regA_i != exp_data_i);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        drain_d = drain_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;

        if (cmp_mis && (err_q != ERR_MAX)) begin
            err_d = err_q + 6'd1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    cnt_d   = num_cycles_i;
                    idx_d   = '0;
                    drain_d = '0;
                    wcnt_d  = '0;
                    err_d   = '0;
                    state_d = (num_cycles_i != '0) ? S_RUN : S_SCAN;
                end
            end

            S_RUN: begin
                // cnt_q is never zero here: a zero request goes straight to SCAN.
                cnt_d = cnt_q - 1'b1;
                if (rwe_i && (rd_i != 5'd0) && (wcnt_q != '1)) begin
                    wcnt_d = wcnt_q + 1'b1;
                end
                if (cnt_q == CYCLE_WIDTH'(1)) begin
                    state_d = S_SCAN;
                end
            end

            S_SCAN: begin
                if (idx_q == LAST_IDX) begin
                    drain_d = '0;
                    state_d = S_DRAIN;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end

            S_DRAIN: begin
                // Stay until the last issued index has been compared.
                if (drain_q == LAST_DRAIN) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            drain_q <= '0;
            wcnt_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            drain_q <= drain_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
        end
    end

    // Reset clears every valid bit, so a compare in flight when reset hits
    // can never surface as a pulse afterwards.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            vld_pipe_q <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                tag_pipe_q[k] <= '0;
            end
        end else begin
            vld_pipe_q[0] <= (state_q == S_SCAN);
            tag_pipe_q[0] <= idx_q;
            for (int k = READ_LATENCY - 1; k > 0; k--) begin
                vld_pipe_q[k] <= vld_pipe_q[k-1];
                tag_pipe_q[k] <= tag_pipe_q[k-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cpu_hold_o       = (state_q != S_RUN);
    assign test_mode_o      = (state_q == S_SCAN) || (state_q == S_DRAIN);
    assign rs1_test_o       = idx_q;
    assign exp_addr_o       = idx_q;
    assign mismatch_valid_o = cmp_mis;
    assign mismatch_reg_o   = cmp_mis ? cmp_tag : 5'd0;
    assign write_count_o    = wcnt_q;
    assign err_count_o      = err_q;
    assign done_o           = (state_q == S_DONE);
    assign pass_o           = (state_q == S_DONE) && (err_q == 6'd0);

endmodule

// File: tb/tb_regfile_scan_checker.sv
// -----------------------------------------------------------------------------
// tb_regfile_scan_checker
//
// Two checkers (READ_LATENCY 1 and 2) share stimulus. Each has its own
// register-file / expected-memory model with matching latency; a bit is
// flipped in regA for registers selected by the 'bad' mask.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_regfile_scan_checker;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] nc;
    logic        rwe;
    logic [4:0]  rd;
    logic [31:0] bad;

    logic        hold [2];
    logic        tm   [2];
    logic [4:0]  rs1  [2];
    logic [4:0]  ea   [2];
    logic [31:0] rega [2];
    logic [31:0] expd [2];
    logic        mv   [2];
    logic [4:0]  mreg [2];
    logic [15:0] wc   [2];
    logic [5:0]  err  [2];
    logic        dn   [2];
    logic        ps   [2];

    int n_tests = 0;
    int n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    regfile_scan_checker #(.READ_LATENCY(1)) u_dut0 (
        .clock_i(clk), .reset_i(rst), .start_i(start), .num_cycles_i(nc),
        .rwe_i(rwe), .rd_i(rd), .cpu_hold_o(hold[0]), .test_mode_o(tm[0]),
        .rs1_test_o(rs1[0]), .exp_addr_o(ea[0]), .regA_i(rega[0]),
        .exp_data_i(expd[0]), .mismatch_valid_o(mv[0]), .mismatch_reg_o(mreg[0]),
        .write_count_o(wc[0]), .err_count_o(err[0]), .done_o(dn[0]), .pass_o(ps[0])
    );

    regfile_scan_checker #(.READ_LATENCY(2)) u_dut1 (
        .clock_i(clk), .reset_i(rst), .start_i(start), .num_cycles_i(nc),
        .rwe_i(rwe), .rd_i(rd), .cpu_hold_o(hold[1]), .test_mode_o(tm[1]),
        .rs1_test_o(rs1[1]), .exp_addr_o(ea[1]), .regA_i(rega[1]),
        .exp_data_i(expd[1]), .mismatch_valid_o(mv[1]), .mismatch_reg_o(mreg[1]),
        .write_count_o(wc[1]), .err_count_o(err[1]), .done_o(dn[1]), .pass_o(ps[1])
    );

    // Memory models: regA follows rs1_test, exp_data follows exp_addr.
    function automatic logic [31:0] golden(input logic [4:0] a);
        return 32'hC0DE_0000 ^ ({27'd0, a} * 32'h0001_0203);
    endfunction

    function automatic logic [31:0] flip(input logic [4:0] a, input logic [31:0] m);
        return m[a] ? (32'h1 << a) : 32'h0;
    endfunction

    logic [4:0] ra0 = '0, ex0 = '0;
    logic [4:0] ra1a = '0, ra1b = '0, ex1a = '0, ex1b = '0;
    always @(posedge clk) begin
        ra0  <= rs1[0];
        ex0  <= ea[0];
        ra1a <= rs1[1];
        ra1b <= ra1a;
        ex1a <= ea[1];
        ex1b <= ex1a;
    end
    assign rega[0] = golden(ra0) ^ flip(ra0, bad);
    assign expd[0] = golden(ex0);
    assign rega[1] = golden(ra1b) ^ flip(ra1b, bad);
    assign expd[1] = golden(ex1b);

    // Monitor: running totals sampled on the falling edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int run_tot [2] = '{0, 0};
    int tm_tot  [2] = '{0, 0};
    int l31_tot [2] = '{0, 0};
    int p_tot   [2] = '{0, 0};
    int ss_cyc  [2] = '{0, 0};
    int pr  [2][64];
    int pcy [2][64];
    logic tm_prev [2] = '{1'b0, 1'b0};

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!hold[d]) run_tot[d]++;
            if (tm[d]) tm_tot[d]++;
            if (tm[d] && rs1[d] == 5'd31) l31_tot[d]++;
            if (tm[d] && !tm_prev[d]) ss_cyc[d] = cyc;
            if (mv[d]) begin
                pr[d][p_tot[d] % 64]  = int'(mreg[d]);
                pcy[d][p_tot[d] % 64] = cyc;
                p_tot[d]++;
            end
            tm_prev[d] = tm[d];
        end
    end

    int s_run [2], s_tm [2], s_l31 [2], s_p [2];
    task automatic snap();
        for (int d = 0; d < 2; d++) begin
            s_run[d] = run_tot[d];
            s_tm[d]  = tm_tot[d];
            s_l31[d] = l31_tot[d];
            s_p[d]   = p_tot[d];
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic [15:0] cycles);
        @(posedge clk); #1;
        nc    = cycles;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!(dn[0] && dn[1]) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_reached", {62'd0, dn[0], dn[1]}, 64'd3);
    endtask

    task automatic chk_reset_vals(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_hold"}, hold[d], 1);
            chk({tag, "_tm"},   tm[d],   0);
            chk({tag, "_rs1"},  rs1[d],  0);
            chk({tag, "_ea"},   ea[d],   0);
            chk({tag, "_mv"},   mv[d],   0);
            chk({tag, "_mreg"}, mreg[d], 0);
            chk({tag, "_wc"},   wc[d],   0);
            chk({tag, "_err"},  err[d],  0);
            chk({tag, "_done"}, dn[d],   0);
            chk({tag, "_pass"}, ps[d],   0);
        end
    endtask

    initial begin
        int n;
        int rl;
        rst = 1'b1; start = 1'b0; nc = '0; rwe = 1'b0; rd = '0; bad = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        rst = 1'b0;

        // Clean run of 5 cycles with writes {0,7,7,2}.
        snap();
        do_start(16'd5);
        rwe = 1'b1; rd = 5'd0;
        @(posedge clk); #1 rd = 5'd7;
        @(posedge clk); #1 rd = 5'd7;
        @(posedge clk); #1 rd = 5'd2;
        @(posedge clk); #1 rwe = 1'b0; rd = 5'd0;
        wait_done();
        for (int d = 0; d < 2; d++) begin
            rl = d + 1;
            chk("t1_run_cycles", run_tot[d] - s_run[d], 5);
            chk("t1_tm_cycles",  tm_tot[d] - s_tm[d], 32 + rl);
            chk("t1_drain",      l31_tot[d] - s_l31[d] - 1, rl);
            chk("t1_pass",       ps[d], 1);
            chk("t1_err",        err[d], 0);
            chk("t1_wc",         wc[d], 3);
            chk("t1_pulses",     p_tot[d] - s_p[d], 0);
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("t1_done_hold", dn[d], 1);
            chk("t1_wc_hold",   wc[d], 3);
            chk("t1_hold_done", hold[d], 1);
            chk("t1_tm_done",   tm[d], 0);
        end

        // Mismatches on registers 3 and 31.
        bad = (32'h1 << 3) | (32'h1 << 31);
        snap();
        do_start(16'd4);
        wait_done();
        for (int d = 0; d < 2; d++) begin
            rl = d + 1;
            chk("t2_err",     err[d], 2);
            chk("t2_pass",    ps[d], 0);
            chk("t2_wc_clr",  wc[d], 0);
            chk("t2_pulses",  p_tot[d] - s_p[d], 2);
            chk("t2_reg_a",   pr[d][s_p[d] % 64], 3);
            chk("t2_reg_b",   pr[d][(s_p[d] + 1) % 64], 31);
            chk("t2_lat3",    pcy[d][s_p[d] % 64] - ss_cyc[d], 3 + rl);
        end

        // Mismatch on register 0 only.
        bad = 32'h1;
        snap();
        do_start(16'd1);
        wait_done();
        for (int d = 0; d < 2; d++) begin
            rl = d + 1;
            chk("t3_err",     err[d], 1);
            chk("t3_pulses",  p_tot[d] - s_p[d], 1);
            chk("t3_reg",     pr[d][s_p[d] % 64], 0);
            chk("t3_lat0",    pcy[d][s_p[d] % 64] - ss_cyc[d], rl);
            chk("t3_drain",   l31_tot[d] - s_l31[d] - 1, rl);
            chk("t3_run",     run_tot[d] - s_run[d], 1);
        end

        // num_cycles=0 goes straight to SCAN; a mid-scan start is ignored.
        bad = '0;
        snap();
        do_start(16'd0);
        for (int d = 0; d < 2; d++) begin
            chk("t4_scan_now", tm[d], 1);
            chk("t4_rs1_0",    rs1[d], 0);
        end
        rwe = 1'b1; rd = 5'd5;
        repeat (3) @(posedge clk);
        #1 nc = 16'd7; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done();
        rwe = 1'b0; rd = '0;
        for (int d = 0; d < 2; d++) begin
            rl = d + 1;
            chk("t4_tm_cycles", tm_tot[d] - s_tm[d], 32 + rl);
            chk("t4_run",       run_tot[d] - s_run[d], 0);
            chk("t4_wc",        wc[d], 0);
            chk("t4_pass",      ps[d], 1);
        end

        // Reset mid-scan at rs1_test=10 with a compare in flight.
        bad = (32'h1 << 9) | (32'h1 << 10) | (32'h1 << 11);
        do_start(16'd0);
        n = 0;
        while (rs1[0] != 5'd10 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t5_reach10", rs1[0], 10);
        #2 rst = 1'b1;
        #1;
        chk_reset_vals("t5_rst");
        snap();
        @(posedge clk); #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("t5_no_pulse", p_tot[d] - s_p[d], 0);
            chk("t5_idle_tm",  tm[d], 0);
            chk("t5_idle_done", dn[d], 0);
        end

        // Full scan after reset.
        bad = 32'h1 << 5;
        snap();
        do_start(16'd2);
        wait_done();
        for (int d = 0; d < 2; d++) begin
            rl = d + 1;
            chk("t6_err",    err[d], 1);
            chk("t6_pulses", p_tot[d] - s_p[d], 1);
            chk("t6_reg",    pr[d][s_p[d] % 64], 5);
            chk("t6_tm",     tm_tot[d] - s_tm[d], 32 + rl);
            chk("t6_pass",   ps[d], 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
